switcher_word_capture: RTL and testbench

Receiving end of the 16-bit ADC/port output bus, located on the consumer side (readout/transfer logic). It registers the bus word together with its Switch code. In ADC mode it detects ReadyBuff rising edges, unpacks {Fast, DataSlow} and queues these samples in a first-word-fall-through FIFO. In port modes it captures the PC/PD word and emits a change strobe.

---
 rtl/switcher_word_capture_if.sv | 36 +++
 rtl/switcher_word_capture.sv | 156 +++++++++++++++
 tb/tb_switcher_word_capture.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/switcher_word_capture_if.sv
// Bus bundle between the producer-side stimulus (master) and the
// consumer-side word capture block (slave).
interface switcher_word_capture_if #(
  parameter int DEPTH_LOG2 = 3
);
  // Bus from the producer, plus the consumer's control inputs
  logic [15:0]         DataIn;
  logic [1:0]          Switch;
  logic                ReadEn;
  logic                ClrOvf;

  // FIFO head and status
  logic [13:0]         SampleOut;
  logic                FastOut;
  logic                Empty;
  logic                Full;
  logic [DEPTH_LOG2:0] Count;
  logic                Overflow;

  // Port-mode capture
  logic [15:0]         PortWord;
  logic                PortSel;
  logic                PortStrobe;

  modport master (
    output DataIn, Switch, ReadEn, ClrOvf,
    input  SampleOut, FastOut, Empty, Full, Count, Overflow,
    input  PortWord, PortSel, PortStrobe
  );

  modport slave (
    input  DataIn, Switch, ReadEn, ClrOvf,
    output SampleOut, FastOut, Empty, Full, Count, Overflow,
    output PortWord, PortSel, PortStrobe
  );
endinterface

// File: rtl/switcher_word_capture.sv
// Consumer-side capture of the 16-bit ADC/port bus.
// ADC mode (Switch=00): ReadyBuff rising edges push {Fast, DataSlow}
// into a first-word-fall-through FIFO with a sticky overflow flag.
// Port modes (01 = PC, 11 = PD): the bus word is captured and a
// one-cycle strobe marks every change of word or source.
module switcher_word_capture #(
  parameter int DEPTH_LOG2 = 3
) (
  input logic                    Clk,
  input logic                    nReset,
  switcher_word_capture_if.slave bus
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Bus mode codes
  localparam logic [1:0] MODE_ADC = 2'b00;

  // Stage-1 registers: word and mode always travel together
  logic [15:0]      r_dq;
  logic [1:0]       r_sq;
  logic [1:0]       r_sq_prev;
  logic             r_p;

  // FIFO state
  logic [14:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  // Port capture state
  logic [15:0]      r_port_word;
  logic             r_port_sel;
  logic             r_port_strobe;

  // Decoded control
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_write;
  logic             w_drop;
  logic             w_port_mode;
  logic             w_port_change;
  logic [14:0]      w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);

  // Rising edge of ReadyBuff seen while in ADC mode
  assign w_push  = (r_sq == MODE_ADC) && r_dq[15] && !r_p;
  assign w_pop   = bus.ReadEn && !w_empty;

  // A full FIFO still accepts a sample if the head leaves in the same cycle
  assign w_write = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // Codes 01 and 11 are the two port modes; both have bit 0 set
  assign w_port_mode   = r_sq[0];
  assign w_port_change = (r_dq != r_port_word) ||
                         (r_sq[1] != r_port_sel) ||
                         (r_sq_prev != r_sq);

  assign w_head = r_mem[r_rptr];

  // Stage 1: register bus word, mode, previous mode and ReadyBuff history
  always_ff @(posedge Clk) begin
    // NOTE: every sequential assignment is non-blocking so all registers
    // update together from the values present before the edge.
    if (!nReset) begin
      r_dq      <= '0;
      r_sq      <= '0;
      r_sq_prev <= '0;
      r_p       <= 1'b1;
    end else begin
      r_dq      <= bus.DataIn;
      r_sq      <= bus.Switch;
      r_sq_prev <= r_sq;
      // Outside ADC mode the history is forced high so re-entering ADC
      // mode with ReadyBuff already high does not count as an edge.
      r_p       <= (r_sq == MODE_ADC) ? r_dq[15] : 1'b1;
    end
  end

  // FIFO storage write port
  always_ff @(posedge Clk) begin
    // NOTE: storage is deliberately left out of reset; validity is tracked
    // by the pointers and count, so clearing the array buys nothing.
    if (w_write) begin
      r_mem[r_wptr] <= r_dq[14:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a drop wins over a simultaneous clear
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.ClrOvf) begin
      r_overflow <= 1'b0;
    end
  end

  // Port-mode capture and change strobe
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_port_word   <= '0;
      r_port_sel    <= 1'b0;
      r_port_strobe <= 1'b0;
    end else if (w_port_mode) begin
      r_port_word   <= r_dq;
      r_port_sel    <= r_sq[1];
      r_port_strobe <= w_port_change;
    end else begin
      r_port_strobe <= 1'b0;
    end
  end

  // Head is shown only while valid so an empty FIFO reads as zero
  assign bus.SampleOut  = w_empty ? '0 : w_head[13:0];
  assign bus.FastOut    = w_empty ? 1'b0 : w_head[14];
  assign bus.Empty      = w_empty;
  assign bus.Full       = w_full;
  assign bus.Count      = r_count;
  assign bus.Overflow   = r_overflow;
  assign bus.PortWord   = r_port_word;
  assign bus.PortSel    = r_port_sel;
  assign bus.PortStrobe = r_port_strobe;

endmodule

// File: tb/tb_switcher_word_capture.sv
// Self-checking bench for switcher_word_capture: directed scenarios
// followed by a randomized run, all compared against a queue-based model.
module tb_switcher_word_capture;

  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk;
  logic n_reset;

  int errors = 0;
  int checks = 0;

  switcher_word_capture_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  switcher_word_capture #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .Clk    (clk),
    .nReset (n_reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the consumer has seen on the bus, the queue of
  // samples waiting to be read, and the port-capture state.
  logic [15:0] m_dq;
  logic [1:0]  m_sq;
  logic [1:0]  m_sq_prev;
  logic        m_ready_hist;
  logic [14:0] m_q[$];
  logic        m_ovf;
  logic [15:0] m_pw;
  logic        m_ps;
  logic        m_strobe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dq = '0; m_sq = '0; m_sq_prev = '0; m_ready_hist = 1'b1;
    m_ovf = 1'b0; m_pw = '0; m_ps = 1'b0; m_strobe = 1'b0;
  endtask

  // Apply one clock edge of behaviour to the model.
  task automatic model_edge();
    bit new_sample;
    bit was_full;
    bit popped;
    if (!n_reset) begin
      model_reset();
      return;
    end
    new_sample = (m_sq == 2'b00) && m_dq[15] && !m_ready_hist;
    was_full   = (m_q.size() == DEPTH);
    popped     = bus.ReadEn && (m_q.size() > 0);
    if (popped) void'(m_q.pop_front());
    if (new_sample) begin
      if (!was_full || popped) m_q.push_back(m_dq[14:0]);
      else m_ovf = 1'b1;
    end
    if (!(new_sample && was_full && !popped) && bus.ClrOvf) m_ovf = 1'b0;
    if (m_sq == 2'b01 || m_sq == 2'b11) begin
      m_strobe = (m_dq != m_pw) || (m_sq[1] != m_ps) || (m_sq_prev != m_sq);
      m_pw     = m_dq;
      m_ps     = m_sq[1];
    end else begin
      m_strobe = 1'b0;
    end
    m_ready_hist = (m_sq == 2'b00) ? m_dq[15] : 1'b1;
    m_sq_prev    = m_sq;
    m_dq         = bus.DataIn;
    m_sq         = bus.Switch;
  endtask

  task automatic compare_all();
    check("empty",  bus.Empty,      m_q.size() == 0);
    check("full",   bus.Full,       m_q.size() == DEPTH);
    check("count",  bus.Count,      m_q.size());
    check("ovf",    bus.Overflow,   m_ovf);
    check("pword",  bus.PortWord,   m_pw);
    check("psel",   bus.PortSel,    m_ps);
    check("strobe", bus.PortStrobe, m_strobe);
    if (m_q.size() > 0) begin
      check("head_data", bus.SampleOut, m_q[0][13:0]);
      check("head_fast", bus.FastOut,   m_q[0][14]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // One-cycle ReadyBuff pulse; the sample is queued by the end of the task.
  task automatic pulse(input logic [13:0] data, input logic fast);
    bus.DataIn = {1'b1, fast, data};
    tick();
    bus.DataIn = '0;
    tick();
  endtask

  initial begin
    model_reset();
    n_reset    = 1'b0;
    bus.DataIn = '0;
    bus.Switch = 2'b00;
    bus.ReadEn = 1'b0;
    bus.ClrOvf = 1'b0;
    #1;

    // Reset state
    tick(); tick();
    n_reset = 1'b1;
    check("rst_sample", bus.SampleOut, 14'h0);
    check("rst_fast",   bus.FastOut,   1'b0);
    check("rst_empty",  bus.Empty,     1'b1);
    check("rst_pword",  bus.PortWord,  16'h0);

    // 1: held ReadyBuff pushes once, two-clock latency
    tick(); tick();
    bus.DataIn = 16'hC123;
    tick();
    check("t1_not_yet", bus.Empty, 1'b1);
    tick();
    check("t1_count",  bus.Count,     4'd1);
    check("t1_sample", bus.SampleOut, 14'h0123);
    check("t1_fast",   bus.FastOut,   1'b1);
    repeat (3) tick();
    check("t1_held", bus.Count, 4'd1);
    bus.ReadEn = 1'b1;
    tick();
    bus.ReadEn = 1'b0;
    check("t1_popped", bus.Empty, 1'b1);
    bus.DataIn = '0;
    tick();

    // 2: overflow after ten pulses, ordered readout, clear
    for (int i = 0; i < 10; i++) pulse(14'(i), 1'b0);
    check("t2_full",  bus.Full,     1'b1);
    check("t2_count", bus.Count,    4'd8);
    check("t2_ovf",   bus.Overflow, 1'b1);
    bus.ReadEn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_order", bus.SampleOut, 14'(i));
      tick();
    end
    bus.ReadEn = 1'b0;
    check("t2_drained", bus.Empty, 1'b1);
    bus.ClrOvf = 1'b1;
    tick();
    bus.ClrOvf = 1'b0;
    check("t2_clr", bus.Overflow, 1'b0);

    // 3: push and pop together while full
    for (int i = 0; i < 8; i++) pulse(14'(16'h20 + i), 1'b0);
    check("t3_full", bus.Full, 1'b1);
    bus.DataIn = 16'h8055;
    tick();
    bus.ReadEn = 1'b1;
    tick();
    bus.ReadEn = 1'b0;
    bus.DataIn = '0;
    check("t3_count", bus.Count,    4'd8);
    check("t3_ovf",   bus.Overflow, 1'b0);
    bus.ReadEn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_order", bus.SampleOut, (i == 7) ? 14'h55 : 14'(16'h21 + i));
      tick();
    end
    bus.ReadEn = 1'b0;
    tick();

    // 4: port modes and re-entry to ADC mode with ReadyBuff high
    bus.DataIn = 16'h8000;
    repeat (3) tick();
    check("t4_adc", bus.Count, 4'd1);
    bus.Switch = 2'b01;
    bus.DataIn = 16'hBEEF;
    tick();
    check("t4_pc_early", bus.PortStrobe, 1'b0);
    tick();
    check("t4_pc_strobe", bus.PortStrobe, 1'b1);
    check("t4_pc_word",   bus.PortWord,   16'hBEEF);
    check("t4_pc_sel",    bus.PortSel,    1'b0);
    tick();
    check("t4_pc_once", bus.PortStrobe, 1'b0);
    bus.Switch = 2'b11;
    bus.DataIn = 16'h1234;
    tick(); tick();
    check("t4_pd_strobe", bus.PortStrobe, 1'b1);
    check("t4_pd_word",   bus.PortWord,   16'h1234);
    check("t4_pd_sel",    bus.PortSel,    1'b1);
    repeat (4) begin
      tick();
      check("t4_pd_quiet", bus.PortStrobe, 1'b0);
    end
    bus.Switch = 2'b00;
    bus.DataIn = 16'h8000;
    repeat (4) tick();
    check("t4_no_push", bus.Count,    4'd1);
    check("t4_hold",    bus.PortWord, 16'h1234);
    bus.ReadEn = 1'b1;
    tick();
    bus.ReadEn = 1'b0;
    bus.DataIn = '0;
    tick();

    // 5: zero-bus mode ignores the bus
    bus.Switch = 2'b10;
    repeat (20) begin
      bus.DataIn = 16'($urandom);
      tick();
      check("t5_strobe", bus.PortStrobe, 1'b0);
    end
    check("t5_count", bus.Count, 4'd0);
    bus.Switch = 2'b00;
    bus.DataIn = '0;
    tick(); tick();

    // 6: reset mid-operation
    for (int i = 0; i < 10; i++) pulse(14'(16'h100 + i), 1'b1);
    bus.ReadEn = 1'b1;
    repeat (3) tick();
    bus.ReadEn = 1'b0;
    check("t6_pre_count", bus.Count,    4'd5);
    check("t6_pre_ovf",   bus.Overflow, 1'b1);
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    check("t6_empty",  bus.Empty,     1'b1);
    check("t6_count",  bus.Count,     4'd0);
    check("t6_ovf",    bus.Overflow,  1'b0);
    check("t6_pword",  bus.PortWord,  16'h0);
    check("t6_sample", bus.SampleOut, 14'h0);
    tick();
    pulse(14'h2AB, 1'b1);
    check("t6_again",  bus.Count,     4'd1);
    check("t6_again_d", bus.SampleOut, 14'h2AB);
    check("t6_again_f", bus.FastOut,   1'b1);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) bus.Switch = 2'b00;
      else bus.Switch = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 2) != 0) bus.DataIn = 16'($urandom);
      bus.ReadEn = ($urandom_range(0, 2) == 0);
      bus.ClrOvf = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
